router_fsm: RTL and testbench
=============================

# router_fsm

Packet-sequencing controller for the 1x3 router input path. It tracks each incoming packet from header byte to parity byte and tells the register block and synchronizer when to latch the address, load data, hold on FIFO full, and check parity. It sits between the router input pins, the synchronizer (which consumes `detect_add` and `write_enb_reg`) and the register block (which consumes the load/state strobes).

## Interface
- Parameters: none. Port count is fixed at 3; address 2'b11 is invalid.
- `clock` in 1: rising-edge clock.
- `resetn` in 1: synchronous, active-low reset.
- `pkt_valid` in 1: high while header and payload bytes are on the input bus.
- `data_in` in 2: destination address, taken from header bits [1:0].
- `fifo_full` in 1: full flag of the currently addressed FIFO, from the synchronizer.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-FIFO timeout soft resets.
- `parity_done` in 1: the register block has latched the parity byte.
- `low_pkt_valid` in 1: the register block saw `pkt_valid` fall while the FSM was in the full state.
- `detect_add` out 1: address-latch strobe.
- `lfd_state` out 1: load first data (header).
- `ld_state` out 1: load payload data.
- `full_state` out 1: FSM is in the FIFO-full hold.
- `laf_state` out 1: load after full.
- `rst_int_reg` out 1: parity-check cycle; clears internal registers.
- `write_enb_reg` out 1: FIFO write request.
- `busy` out 1: source must hold its current byte.

## Operation
- States: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), WAIT_TILL_EMPTY (WTE).
- The FSM captures `addr_q` from `data_in` when it is in DA with `pkt_valid` high and `data_in` != 3.
- Transitions:
  - DA → LFD when `pkt_valid` is high, `data_in` != 3, and `fifo_empty_[data_in]` is high.
  - DA → WTE when `pkt_valid` is high, `data_in` != 3, and `fifo_empty_[data_in]` is low.
  - Otherwise DA stays in DA. A header with `data_in`=3 is ignored and the FSM remains in DA.
  - LFD → LD, unconditionally.
  - LD → FFS if `fifo_full`; else LD → LP if `pkt_valid` is low; else LD stays in LD.
  - FFS → LAF when `fifo_full` is low; else FFS stays in FFS.
  - LAF → DA if `parity_done`; else LAF → LP if `low_pkt_valid`; else LAF → LD.
  - LP → CPE, unconditionally.
  - CPE → FFS if `fifo_full`; else CPE → DA.
  - WTE → LFD when `fifo_empty_[addr_q]` is high; else WTE stays in WTE.
- Transition priority:
  1. `resetn` low.
  2. `soft_reset_[addr_q]` high in any state other than DA: next state is DA.
  3. The normal transitions above.
- Soft resets for non-addressed ports are ignored.
- Outputs are a Moore decode of the state register:
  - `detect_add` = DA.
  - `lfd_state` = LFD.
  - `ld_state` = LD.
  - `full_state` = FFS.
  - `laf_state` = LAF.
  - `rst_int_reg` = CPE.
  - `write_enb_reg` = LD | LP | LAF.
  - `busy` = not (DA or LD).

## Timing
- Reset: state = DA and `addr_q` = 0. Outputs after reset: `detect_add`=1; all other outputs 0, including `busy`.
- Every transition takes one clock. Outputs change in the cycle after the input condition is sampled.
- Header sampled in DA at edge N (empty FIFO):
  - cycle N+1: `lfd_state`=1, `busy`=1.
  - cycle N+2: `ld_state`=1, `write_enb_reg`=1, `busy`=0.
- `pkt_valid` falling while in LD:
  - next cycle is LP (`write_enb_reg`=1, `busy`=1).
  - the cycle after is CPE (`rst_int_reg`=1).
  - then DA.
- `fifo_full` and `pkt_valid`=0 sampled in LD in the same cycle: full wins, next state is FFS.
- `resetn` low mid-packet: DA at the next edge regardless of state; `addr_q` clears.
- Soft reset and `fifo_full` in the same cycle: soft reset wins.

## Structure
- Shared router package holds:
  - the state enum, 3 bits, encodings 0–7 in the order listed above;
  - the invalid-address constant 2'b11;
  - the port-count constant 3.
- No sub-module. The block is a single two-process FSM: a state/`addr_q` register process plus a combinational next-state/output process.
- Empty and soft-reset muxing by `addr_q` is done inline.

## Test plan
- Reset, then `pkt_valid`=1, `data_in`=1, `fifo_empty_1`=1, 4 payload bytes, then `pkt_valid`=0 → state sequence DA, LFD, LD×4, LP, CPE, DA; `write_enb_reg` high for 5 cycles.
- Header `data_in`=2 with `fifo_empty_2`=0 for 6 cycles → `busy` high for 6 cycles in WTE; `fifo_empty_2`=1 → LFD on the next edge.
- In LD, assert `fifo_full` for 3 cycles → FFS×3 (`full_state`=1, `busy`=1), then LAF. With `low_pkt_valid`=1 → LP, then CPE.
- In LD for port 0, assert `soft_reset_0` → DA next cycle. Assert `soft_reset_1` instead → FSM stays in LD.
- Header `data_in`=3 with `pkt_valid`=1 → FSM stays in DA, `detect_add`=1, `lfd_state` never asserts.
- `resetn`=0 for one cycle while in FFS → DA next cycle, `busy`=0, `addr_q`=0.

Source files
------------

// File: rtl/router_fsm_pkg.sv
// Shared definitions for the 1x3 router: packet-sequencing FSM state encoding
// and the port/address constants used by the router input path.
package router_fsm_pkg;

  localparam int unsigned NUM_PORTS    = 3;
  localparam logic [1:0]  INVALID_ADDR = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_e;

endpackage : router_fsm_pkg

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the router input path: follows each packet
// from header to parity byte and strobes the register block and synchronizer.
module router_fsm
  import router_fsm_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       full_state,
  output logic       laf_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;

  logic [NUM_PORTS-1:0] empty_vec;
  logic [NUM_PORTS-1:0] soft_vec;
  logic                 hdr_valid;
  logic                 hdr_empty;
  logic                 addr_empty;
  logic                 addr_soft;

  assign empty_vec = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign soft_vec  = {soft_reset_2, soft_reset_1, soft_reset_0};
  assign hdr_valid = pkt_valid && (data_in != INVALID_ADDR);

  // Port muxes; the invalid address selects nothing so it can never look empty.
  always_comb begin
    hdr_empty  = 1'b0;
    addr_empty = 1'b0;
    addr_soft  = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = empty_vec[0];
      2'd1:    hdr_empty = empty_vec[1];
      2'd2:    hdr_empty = empty_vec[2];
      default: hdr_empty = 1'b0;
    endcase
    case (addr_q)
      2'd0:    begin addr_empty = empty_vec[0]; addr_soft = soft_vec[0]; end
      2'd1:    begin addr_empty = empty_vec[1]; addr_soft = soft_vec[1]; end
      2'd2:    begin addr_empty = empty_vec[2]; addr_soft = soft_vec[2]; end
      default: begin addr_empty = 1'b0;         addr_soft = 1'b0;         end
    endcase
  end

  // NOTE: reset is sampled on the clock edge here, and all state uses <= so
  // every register sees the pre-edge values of its peers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // NOTE: every signal driven below gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    full_state    = 1'b0;
    laf_state     = 1'b0;
    rst_int_reg   = 1'b0;
    write_enb_reg = 1'b0;
    busy          = 1'b1;

    if (state_q != DECODE_ADDRESS && addr_soft) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (hdr_valid) begin
            addr_d  = data_in;
            state_d = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (addr_empty) state_d = LOAD_FIRST_DATA;
        end
        default: state_d = DECODE_ADDRESS;
      endcase
    end

    // Moore decode of the registered state.
    case (state_q)
      DECODE_ADDRESS:     begin detect_add = 1'b1; busy = 1'b0; end
      LOAD_FIRST_DATA:    lfd_state = 1'b1;
      LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b0; end
      FIFO_FULL_STATE:    full_state = 1'b1;
      LOAD_AFTER_FULL:    begin laf_state = 1'b1; write_enb_reg = 1'b1; end
      LOAD_PARITY:        write_enb_reg = 1'b1;
      CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
      default:            busy = 1'b1;
    endcase
  end

endmodule : router_fsm

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: drives packet scenarios and compares the
// Moore outputs (as one vector) against hand-computed per-state values.
module tb_router_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done, low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, full_state, laf_state;
  logic       rst_int_reg, write_enb_reg, busy;

  int checks   = 0;
  int failures = 0;
  int wr_count;
  int busy_count;

  // {detect_add, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy}
  localparam logic [7:0] O_DA  = 8'h80;
  localparam logic [7:0] O_LFD = 8'h41;
  localparam logic [7:0] O_LD  = 8'h22;
  localparam logic [7:0] O_FFS = 8'h11;
  localparam logic [7:0] O_LAF = 8'h0B;
  localparam logic [7:0] O_LP  = 8'h03;
  localparam logic [7:0] O_CPE = 8'h05;
  localparam logic [7:0] O_WTE = 8'h01;

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .full_state(full_state), .laf_state(laf_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] outs();
    return {detect_add, lfd_state, ld_state, full_state, laf_state,
            rst_int_reg, write_enb_reg, busy};
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  // Advance one edge and sample 1 time unit later, away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    if (write_enb_reg) wr_count++;
    if (busy) busy_count++;
  endtask

  task automatic idle_inputs();
    pkt_valid     = 1'b0;
    data_in       = 2'd0;
    fifo_full     = 1'b0;
    fifo_empty_0  = 1'b1;
    fifo_empty_1  = 1'b1;
    fifo_empty_2  = 1'b1;
    soft_reset_0  = 1'b0;
    soft_reset_1  = 1'b0;
    soft_reset_2  = 1'b0;
    parity_done   = 1'b0;
    low_pkt_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    check("reset_outputs", outs(), O_DA);
    check("reset_addr", {6'd0, dut.addr_q}, 8'd0);

    // Packet to port 1 with 4 payload bytes.
    wr_count = 0;
    pkt_valid = 1'b1; data_in = 2'd1;
    tick(); check("p1_lfd", outs(), O_LFD);
    tick(); check("p1_ld1", outs(), O_LD);
    tick(); check("p1_ld2", outs(), O_LD);
    tick(); check("p1_ld3", outs(), O_LD);
    tick(); check("p1_ld4", outs(), O_LD);
    check("p1_addr", {6'd0, dut.addr_q}, 8'd1);
    pkt_valid = 1'b0;
    tick(); check("p1_lp", outs(), O_LP);
    tick(); check("p1_cpe", outs(), O_CPE);
    tick(); check("p1_da", outs(), O_DA);
    check("p1_wr_cycles", 8'(wr_count), 8'd5);

    // Header to port 2 while its FIFO is not empty: wait 6 cycles.
    busy_count = 0;
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
    tick(); check("wte_1", outs(), O_WTE);
    data_in = 2'd0; // another port's empty flag must not release the wait
    for (int i = 2; i <= 6; i++) begin
      tick(); check($sformatf("wte_%0d", i), outs(), O_WTE);
    end
    check("wte_busy_cycles", 8'(busy_count), 8'd6);
    fifo_empty_2 = 1'b1;
    tick(); check("wte_to_lfd", outs(), O_LFD);
    tick(); check("wte_ld", outs(), O_LD);
    pkt_valid = 1'b0;
    tick(); check("wte_lp", outs(), O_LP);
    tick(); check("wte_cpe", outs(), O_CPE);
    tick(); check("wte_da", outs(), O_DA);

    // FIFO full for 3 cycles in LD, then LAF, then LP via low_pkt_valid.
    pkt_valid = 1'b1; data_in = 2'd0;
    tick(); check("ff_lfd", outs(), O_LFD);
    tick(); check("ff_ld", outs(), O_LD);
    fifo_full = 1'b1;
    tick(); check("ff_ffs1", outs(), O_FFS);
    tick(); check("ff_ffs2", outs(), O_FFS);
    tick(); check("ff_ffs3", outs(), O_FFS);
    fifo_full = 1'b0;
    tick(); check("ff_laf", outs(), O_LAF);
    pkt_valid = 1'b0; low_pkt_valid = 1'b1;
    tick(); check("ff_lp", outs(), O_LP);
    low_pkt_valid = 1'b0;
    tick(); check("ff_cpe", outs(), O_CPE);
    tick(); check("ff_da", outs(), O_DA);

    // Full beats pkt_valid low; LAF->LD; CPE with full -> FFS; LAF with parity_done -> DA.
    pkt_valid = 1'b1; data_in = 2'd0;
    tick(); check("pr_lfd", outs(), O_LFD);
    tick(); check("pr_ld", outs(), O_LD);
    fifo_full = 1'b1; pkt_valid = 1'b0;
    tick(); check("pr_full_wins", outs(), O_FFS);
    fifo_full = 1'b0;
    tick(); check("pr_laf", outs(), O_LAF);
    tick(); check("pr_laf_to_ld", outs(), O_LD);
    tick(); check("pr_lp", outs(), O_LP);
    fifo_full = 1'b1;
    tick(); check("pr_cpe", outs(), O_CPE);
    tick(); check("pr_cpe_to_ffs", outs(), O_FFS);
    fifo_full = 1'b0;
    tick(); check("pr_laf2", outs(), O_LAF);
    parity_done = 1'b1;
    tick(); check("pr_laf_to_da", outs(), O_DA);
    parity_done = 1'b0;

    // Soft reset: ignored in DA, honoured for the addressed port only, beats full.
    pkt_valid = 1'b1; data_in = 2'd0; soft_reset_0 = 1'b1;
    tick(); check("sr_ignored_in_da", outs(), O_LFD);
    soft_reset_0 = 1'b0;
    tick(); check("sr_ld", outs(), O_LD);
    soft_reset_1 = 1'b1;
    tick(); check("sr_other_port", outs(), O_LD);
    soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
    tick(); check("sr_own_port", outs(), O_DA);
    soft_reset_0 = 1'b0;
    tick(); check("sr2_lfd", outs(), O_LFD);
    tick(); check("sr2_ld", outs(), O_LD);
    soft_reset_0 = 1'b1; fifo_full = 1'b1;
    tick(); check("sr_beats_full", outs(), O_DA);
    soft_reset_0 = 1'b0; fifo_full = 1'b0; pkt_valid = 1'b0;
    tick(); check("sr_idle", outs(), O_DA);

    // Invalid address 3 is ignored.
    pkt_valid = 1'b1; data_in = 2'd3;
    for (int i = 1; i <= 3; i++) begin
      tick(); check($sformatf("inv_addr_%0d", i), outs(), O_DA);
    end
    pkt_valid = 1'b0;

    // Hard reset while in FFS for port 2.
    pkt_valid = 1'b1; data_in = 2'd2;
    tick(); check("rst_lfd", outs(), O_LFD);
    tick(); check("rst_ld", outs(), O_LD);
    check("rst_addr_before", {6'd0, dut.addr_q}, 8'd2);
    fifo_full = 1'b1;
    tick(); check("rst_ffs", outs(), O_FFS);
    resetn = 1'b0;
    tick(); check("rst_to_da", outs(), O_DA);
    check("rst_addr_after", {6'd0, dut.addr_q}, 8'd0);
    resetn = 1'b1; idle_inputs();
    tick(); check("rst_idle", outs(), O_DA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_router_fsm
